// File: rtl/match_ctl_pkg.sv
// Shared game definitions: match FSM encoding, winner codes and playfield geometry.
package match_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GOAL = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  localparam int FIELD_W   = 640;
  localparam int FIELD_H   = 480;
  localparam int PADDLE_H  = 64;
  localparam int BALL_SIZE = 8;

  // Only meaningful when at least one player has reached the winning score.
  function automatic logic [1:0] winner_code(input logic w1, input logic w2);
    if (w1 && w2) return WIN_DRAW;
    else if (w1)  return WIN_P1;
    else          return WIN_P2;
  endfunction

endpackage

// File: rtl/match_ctl_if.sv
// Match controller bus: start button and scores in, game control and status out.
interface match_ctl_if;
  logic       start;
  logic [3:0] player_1_score;
  logic [3:0] player_2_score;
  logic       game_rst;
  logic       freeze;
  logic       goal_p1;
  logic       goal_p2;
  logic [1:0] winner;
  logic [1:0] state;

  // No handshake: start is a level and scores are sampled every cycle; outputs are
  // registered levels except game_rst, which is a single-cycle pulse.
  modport master (
    output start, player_1_score, player_2_score,
    input  game_rst, freeze, goal_p1, goal_p2, winner, state
  );

  modport slave (
    input  start, player_1_score, player_2_score,
    output game_rst, freeze, goal_p1, goal_p2, winner, state
  );
endinterface

// File: rtl/match_ctl_edge_det.sv
// Registers a level input once and flags its rising edge for one cycle.
module edge_det (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic q;
    logic q_d;
    logic armed;

    // armed stays low until the input has been seen low after reset, so a level
    // already high when reset releases is not mistaken for a new press.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            q     <= 1'b0;
            q_d   <= 1'b0;
            armed <= 1'b0;
        end else begin
            q     <= d;
            q_d   <= q;
            armed <= armed | ~d;
        end
    end

    assign pulse = q & ~q_d & armed;

endmodule

// File: rtl/match_ctl.sv
// Match sequencing: idle, play, post-goal pause and game-over, driving the ball controller.
module match_ctl
  import match_ctl_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 65_000_000
) (
    input logic        clk_in,
    input logic        rst,
    match_ctl_if.slave bus
);

    localparam int              CNT_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [3:0]      WIN_Q    = 4'(WIN_SCORE);

    logic start_ev;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        prev1_q, prev2_q;
    logic              freeze_q, freeze_d;
    logic              game_rst_q, game_rst_d;
    logic              goal1_q, goal1_d;
    logic              goal2_q, goal2_d;
    logic [1:0]        winner_q, winner_d;

    logic live, hit1, hit2, win1, win2;

    edge_det u_start (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (bus.start),
        .pulse  (start_ev)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prev1_q    <= 4'd0;
            prev2_q    <= 4'd0;
            freeze_q   <= 1'b1;
            game_rst_q <= 1'b0;
            goal1_q    <= 1'b0;
            goal2_q    <= 1'b0;
            winner_q   <= WIN_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev1_q    <= bus.player_1_score;
            prev2_q    <= bus.player_2_score;
            freeze_q   <= freeze_d;
            game_rst_q <= game_rst_d;
            goal1_q    <= goal1_d;
            goal2_q    <= goal2_d;
            winner_q   <= winner_d;
        end
    end

    // A goal is exactly one step up (wrapping); any other change, such as the
    // drop to zero after game_rst, only refreshes the previous-score registers.
    always_comb begin
        live = (state_q == ST_PLAY) || (state_q == ST_GOAL);
        hit1 = live && (bus.player_1_score == 4'(prev1_q + 4'd1));
        hit2 = live && (bus.player_2_score == 4'(prev2_q + 4'd1));
        win1 = hit1 && (bus.player_1_score >= WIN_Q);
        win2 = hit2 && (bus.player_2_score >= WIN_Q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        goal1_d    = goal1_q;
        goal2_d    = goal2_q;
        winner_d   = winner_q;
        game_rst_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    state_d    = ST_PLAY;
                    game_rst_d = 1'b1;
                end
            end

            ST_PLAY, ST_GOAL: begin
                if (win1 || win2) begin
                    state_d  = ST_OVER;
                    goal1_d  = goal1_q | hit1;
                    goal2_d  = goal2_q | hit2;
                    winner_d = winner_code(win1, win2);
                    cnt_d    = '0;
                end else if (state_q == ST_PLAY) begin
                    if (hit1 || hit2) begin
                        state_d = ST_GOAL;
                        goal1_d = hit1;
                        goal2_d = hit2;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PLAY;
                    goal1_d = 1'b0;
                    goal2_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    // Further goals during the pause show on the flags but never
                    // lengthen it.
                    cnt_d   = cnt_q + 1'b1;
                    goal1_d = goal1_q | hit1;
                    goal2_d = goal2_q | hit2;
                end
            end

            ST_OVER: begin
                if (start_ev) begin
                    state_d    = ST_PLAY;
                    winner_d   = WIN_NONE;
                    goal1_d    = 1'b0;
                    goal2_d    = 1'b0;
                    game_rst_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        freeze_d = (state_d != ST_PLAY);
    end

    assign bus.state    = state_q;
    assign bus.freeze   = freeze_q;
    assign bus.game_rst = game_rst_q;
    assign bus.goal_p1  = goal1_q;
    assign bus.goal_p2  = goal2_q;
    assign bus.winner   = winner_q;

endmodule

// File: doc/match_ctl.md
MATCH_CTL -- requirements
Module: match_ctl

Interface
REQ-001 Parameter WIN_SCORE, default 7, goals needed to win a match (1..15).
REQ-002 Parameter PAUSE_CYCLES, default 65_000_000, post-goal freeze length in clk_in cycles (1 s at 65 MHz).
REQ-003 clk_in  input  1  system clock, all state on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level from mouse left button; rising edge requests a new match.
REQ-006 player_1_score  input  4  score from ball controller, player 1.
REQ-007 player_2_score  input  4  score from ball controller, player 2.
REQ-008 game_rst  output  1  one-cycle pulse that resets the ball controller and its scores.
REQ-009 freeze  output  1  high while player and ball motion must be held.
REQ-010 goal_p1, goal_p2  output  1 each  high during the pause following a goal by that player.
REQ-011 winner  output  2  0 none, 1 player 1, 2 player 2, 3 draw.
REQ-012 state  output  2  encoded FSM state for the display overlay.

Function
REQ-013 The FSM SHALL have states IDLE=0, PLAY=1, GOAL=2, OVER=3.
REQ-014 The start input SHALL be registered once and edge-detected; a start event is registered-high with previous registered-low.
REQ-015 IDLE: freeze=1; on a start event go to PLAY and assert game_rst for exactly that transition cycle.
REQ-016 PLAY: freeze=0; previous scores (prev_s1, prev_s2) SHALL be registered every cycle.
REQ-017 A goal for player N SHALL be detected when score_N == prev_sN + 1 (4-bit wrap, 15->0 counts); any other change (e.g. drop to 0 after game_rst) SHALL update prev_sN without a goal.
REQ-018 On a goal in PLAY: if the new score >= WIN_SCORE go to OVER, else go to GOAL; transition occurs the cycle after the score change is seen.
REQ-019 Simultaneous goals by both players in one cycle SHALL set both goal_p1 and goal_p2; if both reach WIN_SCORE, winner=3.
REQ-020 GOAL: freeze=1, goal flag(s) held, a pause counter counts 0..PAUSE_CYCLES-1; on terminal count clear flags, clear counter, return to PLAY.
REQ-021 Goals arriving during GOAL SHALL still update prev registers and SHALL be evaluated for OVER; they SHALL NOT restart the counter.
REQ-022 OVER: freeze=1, winner held stable; on a start event go to PLAY, clear winner and flags, pulse game_rst.
REQ-023 Start events in PLAY or GOAL SHALL be ignored.
REQ-024 Pause counter width SHALL be $clog2(PAUSE_CYCLES) bits minimum, no overflow for any legal parameter.
REQ-025 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-026 On rst: state=IDLE, freeze=1, game_rst=0, goal_p1=goal_p2=0, winner=0, counter=0, prev_s1=prev_s2=0, start register=0.
REQ-027 rst asserted mid-GOAL or mid-OVER SHALL return to IDLE the same edge with all outputs at reset values.
REQ-028 A start level held high through reset release SHALL NOT produce a start event.

Structure
REQ-029 State encodings and winner codes SHALL live in the shared game package alongside field geometry constants.
REQ-030 One sub-module, edge_det (register + rising-edge pulse), SHALL be used for start; all else is flat.

Verification
REQ-031 Reset, then start rising edge -> game_rst one cycle high, state=1, freeze=0 next cycle.
REQ-032 PAUSE_CYCLES=8, player_1_score 0->1 in PLAY -> goal_p1=1, freeze=1 for 8 cycles, then state=1, goal_p1=0.
REQ-033 WIN_SCORE=3, player_2_score steps to 3 -> state=3, winner=2, start then yields game_rst pulse, winner=0.
REQ-034 WIN_SCORE=3, both scores 2->3 same cycle -> state=3, winner=3, goal_p1=goal_p2=1.
REQ-035 Scores drop 5->0 in PLAY -> no goal flag, state stays 1; start pulses in PLAY -> no game_rst.
REQ-036 rst pulse during GOAL counter=4 -> state=0, counter=0, freeze=1, flags 0; start held high across release -> stays IDLE.
